// File: rtl/fifo_sync_stream.sv
// fifo_sync_stream: FWFT valid/ready FIFO with live almost thresholds, sync flush and high watermark
module fifo_sync_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  empty,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic                  almost_full,
    output logic                  almost_empty,
    input  logic                  wm_clear,
    output logic [ADDR_WIDTH:0]   wm_level
);
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH:0] wr_ptr, rd_ptr, level_next;
    logic push, pop;
    always_comb begin
        full         = level == (ADDR_WIDTH+1)'(FIFO_DEPTH);
        empty        = level == '0;
        s_ready      = !full;
        m_valid      = !empty;
        push         = s_valid && s_ready;
        pop          = m_valid && m_ready;
        level_next   = flush ? '0 : level + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, pop};
        m_data       = m_valid ? mem[rd_ptr[ADDR_WIDTH-1:0]] : '0;
        almost_full  = level >= af_thresh;
        almost_empty = level <= ae_thresh;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            wm_level <= '0;
        end else begin
            wr_ptr   <= flush ? '0 : wr_ptr + {{ADDR_WIDTH{1'b0}}, push};
            rd_ptr   <= flush ? '0 : rd_ptr + {{ADDR_WIDTH{1'b0}}, pop};
            level    <= level_next;
            wm_level <= (wm_clear || level_next > wm_level) ? level_next : wm_level;
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[ADDR_WIDTH-1:0]] <= s_data;
    end
endmodule

// File: tb/tb_fifo_sync_stream.sv
// tb_fifo_sync_stream: randomized and directed checks of fifo_sync_stream against a queue model
module tb_fifo_sync_stream;
    localparam int DW = 8;
    localparam int D  = 16;
    localparam int AW = 4;
    logic clk = 0, rst_n = 0, flush = 0, s_valid = 0, m_ready = 0, wm_clear = 0;
    logic [DW-1:0] s_data = '0;
    logic [AW:0] af_thresh = 5'd12, ae_thresh = 5'd3;
    logic s_ready, m_valid, full, empty, almost_full, almost_empty;
    logic [DW-1:0] m_data;
    logic [AW:0] level, wm_level;
    logic [DW-1:0] q[$];
    int wm, vectors, errors;
    fifo_sync_stream #(.DATA_WIDTH(DW), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .level(level), .full(full), .empty(empty),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .wm_clear(wm_clear), .wm_level(wm_level)
    );
    always #5 clk = ~clk;
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic compare_all();
        int n = q.size();
        check("level", 32'(level), n);
        check("s_ready", 32'(s_ready), 32'(n < D));
        check("m_valid", 32'(m_valid), 32'(n > 0));
        check("full", 32'(full), 32'(n == D));
        check("empty", 32'(empty), 32'(n == 0));
        check("m_data", 32'(m_data), n > 0 ? 32'(q[0]) : 32'd0);
        check("almost_full", 32'(almost_full), 32'(n >= int'(af_thresh)));
        check("almost_empty", 32'(almost_empty), 32'(n <= int'(ae_thresh)));
        check("wm_level", 32'(wm_level), wm);
    endtask
    // Checks current outputs, then advances model and DUT by one clock; returns at the next negedge.
    task automatic tick();
        bit push, pop;
        compare_all();
        push = s_valid && q.size() < D;
        pop  = m_ready && q.size() > 0;
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(s_data);
        end
        wm = (wm_clear || q.size() > wm) ? q.size() : wm;
        @(negedge clk);
    endtask
    task automatic reset_pulse();
        rst_n = 0;
        #2;
        q.delete();
        wm = 0;
        compare_all();
        #1 rst_n = 1;
    endtask
    task automatic fill_to(int n);
        s_valid = 1; m_ready = 0;
        while (q.size() < n) begin
            s_data = DW'($urandom);
            tick();
        end
        s_valid = 0;
    endtask
    task automatic drain_to(int n);
        s_valid = 0; m_ready = 1;
        while (q.size() > n) tick();
        m_ready = 0;
    endtask
    initial begin
        int pushes, cyc, maxl;
        @(negedge clk);
        reset_pulse();
        tick();
        // Fill with a known ramp, try one extra push, then drain in order.
        s_valid = 1;
        for (int i = 0; i < D; i++) begin
            s_data = DW'(i);
            tick();
        end
        s_data = 8'hAA;
        tick();
        check("t2_full_level", 32'(level), D);
        s_valid = 0; m_ready = 1;
        for (int i = 0; i < D; i++) begin
            check("t2_order", 32'(m_data), i);
            tick();
        end
        m_ready = 0;
        check("t2_empty", 32'(empty), 1);
        // Simultaneous push/pop at both boundaries.
        fill_to(D);
        s_valid = 1; m_ready = 1; s_data = 8'h5C;
        tick();
        check("t3_full_pop", 32'(level), D - 1);
        drain_to(0);
        s_valid = 1; m_ready = 1; s_data = 8'hC5;
        tick();
        s_valid = 0; m_ready = 0;
        check("t3_empty_push", 32'(level), 1);
        check("t3_m_valid", 32'(m_valid), 1);
        check("t3_m_data", 32'(m_data), 32'h00C5);
        tick();
        // Random streaming with wrapping pointers and watermark tracking.
        wm_clear = 1;
        tick();
        wm_clear = 0;
        pushes = 0; cyc = 0; maxl = q.size();
        while (pushes < 200 && cyc < 5000) begin
            s_valid = 1'($urandom);
            m_ready = 1'($urandom);
            s_data  = DW'($urandom);
            if (s_valid && q.size() < D) pushes++;
            tick();
            if (q.size() > maxl) maxl = q.size();
            cyc++;
        end
        check("t4_budget", 32'(pushes >= 200), 1);
        check("t4_wm_max", 32'(wm_level), maxl);
        drain_to(0);
        // Thresholds, including a live change of af_thresh.
        af_thresh = 5'd12; ae_thresh = 5'd3;
        fill_to(11);
        check("t5_af_11", 32'(almost_full), 0);
        fill_to(12);
        check("t5_af_12", 32'(almost_full), 1);
        drain_to(10);
        check("t5_af_10", 32'(almost_full), 0);
        af_thresh = 5'd8;
        #1 check("t5_af_live", 32'(almost_full), 1);
        tick();
        drain_to(4);
        check("t5_ae_4", 32'(almost_empty), 0);
        drain_to(3);
        check("t5_ae_3", 32'(almost_empty), 1);
        drain_to(0);
        // Flush keeps the watermark; wm_clear resets it.
        wm_clear = 1;
        tick();
        wm_clear = 0;
        fill_to(7);
        flush = 1; s_valid = 1; s_data = 8'h77;
        tick();
        flush = 0; s_valid = 0;
        check("t6_flush_level", 32'(level), 0);
        check("t6_flush_empty", 32'(empty), 1);
        check("t6_wm_kept", 32'(wm_level), 7);
        wm_clear = 1;
        tick();
        wm_clear = 0;
        check("t6_wm_clear", 32'(wm_level), 0);
        for (int i = 0; i < 12; i++) begin
            s_valid = 1'($urandom);
            m_ready = 1'($urandom);
            s_data  = DW'($urandom);
            tick();
        end
        fill_to(5);
        reset_pulse();
        check("t6_rst_level", 32'(level), 0);
        check("t6_rst_wm", 32'(wm_level), 0);
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'($urandom);
            m_ready = 1'($urandom);
            s_data  = DW'($urandom);
            tick();
        end
        s_valid = 0; m_ready = 0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
